fifo_uart_tx: RTL and testbench

Read-side consumer for the 16-entry synchronous byte FIFO. Whenever enabled and the FIFO is non-empty, it pops one byte and serialises it on a UART-style line: a start bit, 8 data bits LSB-first, then stop bit(s). It sits directly on the FIFO read port (`rd`, `fifo_empty`, `data_out`) and closes the write→buffer→line path.

---
 rtl/fifo_uart_pkg.sv | 18 +
 rtl/fifo_uart_tx_uart_bit_timer.sv | 24 ++
 rtl/fifo_uart_tx.sv | 107 ++++++++++
 tb/tb_fifo_uart_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // Cycles from the first start-bit cycle through the last stop-bit cycle.
  function automatic int frame_len(input int clks_per_bit, input int stop_bits);
    return (1 + DATA_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

  // Free-running bit-period counter; held at zero while cleared, wraps on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (clear || tick)  r_cnt <= '0;
    else                     r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serialises them as 8N1/8N2 frames.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  tx_state_t  r_state, w_state_nx;
  logic [7:0] r_shreg, w_shreg_nx;
  logic [2:0] r_idx,   w_idx_nx;
  logic       r_tx,    w_tx_nx;
  logic       r_done,  w_done_nx;
  logic       w_tick;
  logic       w_clear;

  // Pop only from IDLE; gated by reset so nothing is consumed while held in reset.
  assign fifo_rd   = rst_n & (r_state == IDLE) & tx_en & ~fifo_empty;
  assign w_clear   = (r_state == IDLE);
  assign tx        = r_tx;
  assign busy      = (r_state != IDLE);
  assign byte_done = r_done;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // State, shift register, bit index, registered line and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shreg <= w_shreg_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
      r_done  <= w_done_nx;
    end
  end

  // Next-state logic; the line level is derived from the next state so tx is a flop.
  always_comb begin
    w_state_nx = r_state;
    w_shreg_nx = r_shreg;
    w_idx_nx   = r_idx;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (fifo_rd) begin
          w_shreg_nx = fifo_data;
          w_idx_nx   = '0;
          w_state_nx = START;
        end
      end
      START: begin
        if (w_tick) w_state_nx = DATA;
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == 3'(DATA_BITS - 1)) begin
            w_idx_nx   = '0;
            w_state_nx = STOP;
          end else begin
            w_shreg_nx = {1'b0, r_shreg[7:1]};
            w_idx_nx   = r_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // r_idx is reused to count stop bits.
        if (w_tick) begin
          if (r_idx == 3'(STOP_BITS - 1)) begin
            w_idx_nx   = '0;
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_idx_nx   = r_idx + 3'd1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
    case (w_state_nx)
      START:   w_tx_nx = 1'b0;
      DATA:    w_tx_nx = w_shreg_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two DUTs (C=4/1 stop, C=16/2 stop) fed by small FIFO models.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b1;
  logic sel = 1'b0;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

  logic       f1_empty, f2_empty, rd1, rd2, tx1, tx2, busy1, busy2, done1, done2;
  logic [7:0] f1_data, f2_data;
  logic       m_tx, m_busy, m_rd, m_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign f1_empty = (wp1 == rp1);
  assign f2_empty = (wp2 == rp2);
  assign f1_data  = mem1[rp1 % 16];
  assign f2_data  = mem2[rp2 % 16];

  always @(posedge clk) if (rd1) rp1 <= rp1 + 1;
  always @(posedge clk) if (rd2) rp2 <= rp2 + 1;

  assign m_tx   = sel ? tx2   : tx1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_rd   = sel ? rd2   : rd1;
  assign m_done = sel ? done2 : done1;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(f1_empty),
    .fifo_data(f1_data), .fifo_rd(rd1), .tx(tx1), .busy(busy1), .byte_done(done1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(f2_empty),
    .fifo_data(f2_data), .fifo_rd(rd2), .tx(tx2), .busy(busy2), .byte_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wp1 % 16] = b;
    wp1 = wp1 + 1;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wp2 % 16] = b;
    wp2 = wp2 + 1;
  endtask

  // Called when the pop cycle (cycle 0) is visible; ends on the byte_done cycle.
  task automatic frame(input logic [7:0] b, input int c, input int s,
                       input int drop_at, input int abort_at);
    int   n;
    logic e;
    n = frame_len(c, s);
    chk("rd_start", {31'd0, m_rd}, 1);
    for (int cyc = 1; cyc <= n; cyc++) begin
      @(negedge clk);
      if (cyc <= c)          e = 1'b0;
      else if (cyc <= 9 * c) e = b[(cyc - 1) / c - 1];
      else                   e = 1'b1;
      chk("tx_bit",   {31'd0, m_tx},   {31'd0, e});
      chk("busy_mid", {31'd0, m_busy}, 1);
      chk("rd_mid",   {31'd0, m_rd},   0);
      chk("done_mid", {31'd0, m_done}, 0);
      if (cyc == drop_at) tx_en = 1'b0;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("tx_rst",   {31'd0, m_tx},   1);
        chk("busy_rst", {31'd0, m_busy}, 0);
        chk("rd_rst",   {31'd0, m_rd},   0);
        return;
      end
    end
    @(negedge clk);
    chk("done",     {31'd0, m_done}, 1);
    chk("busy_end", {31'd0, m_busy}, 0);
    chk("tx_idle",  {31'd0, m_tx},   1);
  endtask

  initial begin
    int pulses;

    // Reset state, then no pops with an empty FIFO.
    @(negedge clk);
    chk("rst_tx",   {31'd0, tx1},   1);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_rd",   {31'd0, rd1},   0);
    chk("rst_done", {31'd0, done1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd1) pulses++;
    end
    chk("empty_no_rd", pulses, 0);
    chk("empty_tx",    {31'd0, tx1}, 1);

    // Single byte 0xA5.
    push1(8'hA5);
    #1;
    frame(8'hA5, 4, 1, 0, 0);
    chk("a5_rd_after", {31'd0, rd1}, 0);

    // Back-to-back 0x00, 0xFF, 0x3C, 41 cycles apart.
    tx_en = 1'b0;
    push1(8'h00); push1(8'hFF); push1(8'h3C);
    @(negedge clk);
    tx_en = 1'b1;
    #1;
    frame(8'h00, 4, 1, 0, 0);
    frame(8'hFF, 4, 1, 0, 0);
    frame(8'h3C, 4, 1, 0, 0);
    chk("b2b_rd_after", {31'd0, rd1},      0);
    chk("b2b_empty",    {31'd0, f1_empty}, 1);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd1) pulses++;
    end
    chk("b2b_no_rd", pulses, 0);

    // tx_en dropped at cycle 10: frame completes, next byte waits.
    tx_en = 1'b0;
    push1(8'h5A); push1(8'hC3);
    @(negedge clk);
    tx_en = 1'b1;
    #1;
    frame(8'h5A, 4, 1, 10, 0);
    chk("drop_rd_end", {31'd0, rd1}, 0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd1) pulses++;
    end
    chk("drop_no_rd", pulses, 0);
    chk("drop_tx",    {31'd0, tx1}, 1);
    tx_en = 1'b1;
    #1;
    frame(8'hC3, 4, 1, 0, 0);
    chk("drop_rd_after", {31'd0, rd1}, 0);

    // Reset at cycle 20 mid-frame: 0x96 lost, 0x2B follows normally.
    tx_en = 1'b0;
    push1(8'h96); push1(8'h2B);
    @(negedge clk);
    tx_en = 1'b1;
    #1;
    frame(8'h96, 4, 1, 0, 20);
    @(negedge clk);
    chk("rst_hold_tx", {31'd0, tx1}, 1);
    chk("rst_hold_rd", {31'd0, rd1}, 0);
    rst_n = 1'b1;
    #1;
    frame(8'h2B, 4, 1, 0, 0);
    chk("rst_rd_after", {31'd0, rd1},      0);
    chk("rst_empty",    {31'd0, f1_empty}, 1);

    // Two stop bits, C=16, byte 0x81: byte_done at cycle 177.
    sel = 1'b1;
    push2(8'h81);
    #1;
    frame(8'h81, 16, 2, 0, 0);
    chk("s2_rd_after", {31'd0, rd2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
